alu_issue_stage: RTL and testbench

- Sequential front/back stage wrapped around the combinational 32-bit ALU (result, carryout, zero, overflow; 3-bit command).
- Accepts operations on a valid/ready input and drives registered, glitch-free operands and command into the ALU.
- Waits a fixed settle interval for gate-level propagation, then captures result and flags into an output register with valid/ready handshake.

---
 rtl/alu_issue_stage_if.sv | 44 ++++
 rtl/alu_issue_stage.sv | 109 ++++++++++
 tb/tb_alu_issue_stage.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_stage_if.sv
// Bundle of the issue stage's upstream, ALU-facing and downstream signals.
// The stage connects through "slave"; the environment driving it uses "master".
interface alu_issue_stage_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_cmd;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_cmd;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carryout;
  logic             alu_zero;
  logic             alu_overflow;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_carryout;
  logic             out_zero;
  logic             out_overflow;
  logic [2:0]       out_cmd;
  logic [15:0]      op_count;

  modport slave (
    input  in_valid, in_a, in_b, in_cmd,
    input  alu_result, alu_carryout, alu_zero, alu_overflow,
    input  out_ready,
    output in_ready, alu_a, alu_b, alu_cmd,
    output out_valid, out_result, out_carryout, out_zero, out_overflow, out_cmd, op_count
  );

  modport master (
    output in_valid, in_a, in_b, in_cmd,
    output alu_result, alu_carryout, alu_zero, alu_overflow,
    output out_ready,
    input  in_ready, alu_a, alu_b, alu_cmd,
    input  out_valid, out_result, out_carryout, out_zero, out_overflow, out_cmd, op_count
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Registered issue stage around a combinational ALU: holds operands steady for
// SETTLE_CYCLES clocks, then captures result and flags behind a valid/ready output.
module alu_issue_stage #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 8,
  parameter int CNT_WIDTH     = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  alu_issue_stage_if.slave  bus,
  output logic [1:0]        dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid holders keep data stable until that edge.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(SETTLE_CYCLES - 1);

  state_e               state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [2:0]           cmd_q;
  logic [WIDTH-1:0]     res_q;
  logic                 carry_q;
  logic                 zero_q;
  logic                 ovf_q;
  logic [2:0]           out_cmd_q;
  logic                 out_valid_q;
  logic [15:0]          op_count_q;
  logic [15:0]          op_count_d;
  logic                 accept;
  logic                 pop;

  // out_ready reaches in_ready combinationally so a pop and the next accept
  // can share one edge.
  assign bus.in_ready = (state_q == IDLE) | ((state_q == HOLD) & bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;
  assign pop          = out_valid_q & bus.out_ready;
  assign op_count_d   = op_count_q + 16'd1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cmd_q       <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_cmd_q   <= '0;
      out_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: ;
        SETTLE: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_WIDTH'(1);
          end else begin
            res_q       <= bus.alu_result;
            carry_q     <= bus.alu_carryout;
            zero_q      <= bus.alu_zero;
            ovf_q       <= bus.alu_overflow;
            out_cmd_q   <= cmd_q;
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          if (pop) begin
            op_count_q  <= op_count_d;
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      // Accept is only possible in IDLE or HOLD; it overrides the HOLD->IDLE move.
      if (accept) begin
        a_q     <= bus.in_a;
        b_q     <= bus.in_b;
        cmd_q   <= bus.in_cmd;
        cnt_q   <= CNT_LOAD;
        state_q <= SETTLE;
      end
    end
  end

  assign bus.alu_a        = a_q;
  assign bus.alu_b        = b_q;
  assign bus.alu_cmd      = cmd_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_result   = res_q;
  assign bus.out_carryout = carry_q;
  assign bus.out_zero     = zero_q;
  assign bus.out_overflow = ovf_q;
  assign bus.out_cmd      = out_cmd_q;
  assign bus.op_count     = op_count_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: a slow ALU model, a table of operations with
// hand-computed results, and sequences for backpressure, reset and streaming.
module tb_alu_issue_stage;
  localparam int W = 32;
  localparam int S = 4;
  localparam int EW = 38;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] dbg_state;
  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;
  int exp_ops = 0;
  logic [EW-1:0] exp_q[$];

  alu_issue_stage_if #(.WIDTH(W)) bus ();

  alu_issue_stage #(.WIDTH(W), .SETTLE_CYCLES(S), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU model: outputs are inverted until the inputs have been stable long enough.
  logic [W-1:0] t_res;
  logic t_c, t_o;
  logic [32:0] t_sum;
  int stable = 0;
  logic [66:0] prev_in = '0;
  logic settled;

  always_comb begin
    t_sum = '0;
    t_c = 1'b0;
    t_o = 1'b0;
    t_res = '0;
    case (bus.alu_cmd)
      3'b000: begin
        t_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        t_res = t_sum[31:0]; t_c = t_sum[32];
        t_o = (bus.alu_a[31] == bus.alu_b[31]) && (t_res[31] != bus.alu_a[31]);
      end
      3'b001: begin
        t_sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 33'd1;
        t_res = t_sum[31:0]; t_c = t_sum[32];
        t_o = (bus.alu_a[31] != bus.alu_b[31]) && (t_res[31] != bus.alu_a[31]);
      end
      3'b010: t_res = bus.alu_a ^ bus.alu_b;
      3'b011: t_res = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 32'd1 : 32'd0;
      3'b100: t_res = bus.alu_a & bus.alu_b;
      3'b101: t_res = ~(bus.alu_a & bus.alu_b);
      3'b110: t_res = ~(bus.alu_a | bus.alu_b);
      default: t_res = bus.alu_a | bus.alu_b;
    endcase
  end

  always @(negedge clk) begin
    if ({bus.alu_cmd, bus.alu_a, bus.alu_b} != prev_in) stable <= 0;
    else if (stable < 1000) stable <= stable + 1;
    prev_in <= {bus.alu_cmd, bus.alu_a, bus.alu_b};
  end

  assign settled          = (stable >= S - 1);
  assign bus.alu_result   = settled ? t_res : ~t_res;
  assign bus.alu_carryout = settled ? t_c : ~t_c;
  assign bus.alu_zero     = settled ? (t_res == '0) : (t_res != '0);
  assign bus.alu_overflow = settled ? t_o : ~t_o;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [EW-1:0] pack_exp(input logic [2:0] cmd, input logic c,
                                             input logic z, input logic o, input logic [W-1:0] r);
    return {cmd, c, z, o, r};
  endfunction

  // Scoreboard: compare on the cycle before each pop edge.
  always @(negedge clk) begin
    if (reset_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'(bus.out_result), 64'hDEAD);
      end else begin
        check("scoreboard",
              64'({bus.out_cmd, bus.out_carryout, bus.out_zero, bus.out_overflow, bus.out_result}),
              64'(exp_q.pop_front()));
      end
    end
  end

  typedef struct {
    logic [2:0]   cmd;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         o;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  task automatic drive_op(input logic [2:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int acc_cyc);
    bit got = 0;
    bus.in_valid = 1'b1;
    bus.in_cmd = cmd;
    bus.in_a = a;
    bus.in_b = b;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(output int rise_cyc);
    bit got = 0;
    rise_cyc = cyc;
    for (int n = 0; n < 64; n++) begin
      if (bus.out_valid) begin
        got = 1;
        rise_cyc = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!got) check("out_valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_vec(input int i, output int acc_cyc);
    int rise;
    exp_q.push_back(pack_exp(vecs[i].cmd, vecs[i].c, vecs[i].z, vecs[i].o, vecs[i].res));
    drive_op(vecs[i].cmd, vecs[i].a, vecs[i].b, acc_cyc);
    wait_out_valid(rise);
    check("latency", 64'(rise - acc_cyc), 64'(S));
    @(posedge clk);
    #1;
    exp_ops++;
    check("op_count", 64'(bus.op_count), 64'(exp_ops));
  endtask

  initial begin
    int acc, rise, rel, idx, prev_ov;
    bit seen;
    int rises[$];

    vecs[0]  = '{3'b000, 32'h1,        32'h1,        32'h2,        1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'b011, 32'h1,        32'h2,        32'h1,        1'b0, 1'b0, 1'b0};
    vecs[2]  = '{3'b011, 32'h2,        32'h1,        32'h0,        1'b0, 1'b1, 1'b0};
    vecs[3]  = '{3'b001, 32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{3'b000, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b1, 1'b0};
    vecs[5]  = '{3'b000, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{3'b001, 32'h5,        32'h5,        32'h0,        1'b1, 1'b1, 1'b0};
    vecs[7]  = '{3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{3'b100, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{3'b101, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FFF0FFF, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{3'b110, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{3'b111, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{3'b011, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1'b0, 1'b0};

    // Reset held with a pending operation.
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_cmd = vecs[0].cmd;
    bus.in_a = vecs[0].a;
    bus.in_b = vecs[0].b;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_alu_a", 64'(bus.alu_a), 64'd0);
    check("rst_alu_cmd", 64'(bus.alu_cmd), 64'd0);
    check("rst_out_data",
          64'({bus.out_cmd, bus.out_carryout, bus.out_zero, bus.out_overflow, bus.out_result}), 64'd0);
    check("rst_op_count", 64'(bus.op_count), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    rel = cyc;

    for (int i = 0; i < NV; i++) begin
      run_vec(i, acc);
      if (i == 0) check("first_accept", 64'(acc - rel), 64'd1);
    end

    // Backpressure: result held, second op waits, then pop and accept share an edge.
    bus.out_ready = 1'b0;
    exp_q.push_back(pack_exp(3'b000, 1'b0, 1'b0, 1'b0, 32'd7));
    drive_op(3'b000, 32'd3, 32'd4, acc);
    wait_out_valid(rise);
    check("bp_latency", 64'(rise - acc), 64'(S));
    bus.in_valid = 1'b1;
    bus.in_cmd = 3'b001;
    bus.in_a = 32'd10;
    bus.in_b = 32'd4;
    exp_q.push_back(pack_exp(3'b001, 1'b1, 1'b0, 1'b0, 32'd6));
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_out_result", 64'(bus.out_result), 64'd7);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_alu_a", 64'(bus.alu_a), 64'd3);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_comb", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    acc = cyc;
    bus.in_valid = 1'b0;
    exp_ops++;
    check("bp_alu_a_next", 64'(bus.alu_a), 64'd10);
    check("bp_out_valid_low", 64'(bus.out_valid), 64'd0);
    check("bp_state", 64'(dbg_state), 64'd1);
    check("bp_op_count", 64'(bus.op_count), 64'(exp_ops));
    wait_out_valid(rise);
    check("bp2_latency", 64'(rise - acc), 64'(S));
    @(posedge clk);
    #1;
    exp_ops++;
    check("bp2_op_count", 64'(bus.op_count), 64'(exp_ops));

    // Reset two cycles after accept discards the operation.
    drive_op(3'b000, 32'd9, 32'd9, acc);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_ops = 0;
    seen = 0;
    for (int n = 0; n < 12; n++) begin
      if (bus.out_valid) seen = 1;
      @(posedge clk);
      #1;
    end
    check("mid_rst_no_valid", 64'(seen), 64'd0);
    check("mid_rst_op_count", 64'(bus.op_count), 64'd0);
    check("mid_rst_alu_a", 64'(bus.alu_a), 64'd0);
    check("mid_rst_state", 64'(dbg_state), 64'd0);

    // Back-to-back stream with valid and ready held high.
    exp_q.push_back(pack_exp(3'b000, 1'b0, 1'b0, 1'b0, 32'd30));
    exp_q.push_back(pack_exp(3'b001, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF));
    exp_q.push_back(pack_exp(3'b010, 1'b0, 1'b0, 1'b0, 32'h000000FF));
    idx = 0;
    prev_ov = 0;
    bus.in_valid = 1'b1;
    bus.in_cmd = 3'b000; bus.in_a = 32'd10; bus.in_b = 32'd20;
    for (int n = 0; n < 60 && rises.size() < 3; n++) begin
      bit acc_now;
      @(negedge clk);
      acc_now = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (acc_now) begin
        idx++;
        if (idx == 1) begin bus.in_cmd = 3'b001; bus.in_a = 32'd0;  bus.in_b = 32'd1;  end
        else if (idx == 2) begin bus.in_cmd = 3'b010; bus.in_a = 32'h0F; bus.in_b = 32'hF0; end
        else bus.in_valid = 1'b0;
      end
      if (bus.out_valid && prev_ov == 0) rises.push_back(cyc);
      prev_ov = int'(bus.out_valid);
    end
    check("b2b_rises", 64'(rises.size()), 64'd3);
    if (rises.size() == 3) begin
      check("b2b_gap0", 64'(rises[1] - rises[0]), 64'(S + 1));
      check("b2b_gap1", 64'(rises[2] - rises[1]), 64'(S + 1));
    end
    @(posedge clk);
    #1;
    check("b2b_op_count", 64'(bus.op_count), 64'd3);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
